// File: rtl/regfile_wr_arbiter_if.sv
// Purpose : Bundles the requester handshake and register-file write port of
//           regfile_wr_arbiter.
// Signals : req_valid/req_addr/req_data/wr_stall (requester side -> arbiter),
//           req_ready (arbiter -> requesters),
//           rf_we/rf_waddr/rf_wdata/rf_wsrc (arbiter -> register file).
// Modports: master = requesters + register-file side, slave = arbiter.
interface regfile_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 5
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]  req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wr_stall;
  logic                      rf_we;
  logic [ADDR_W-1:0]         rf_waddr;
  logic [WIDTH-1:0]          rf_wdata;
  logic [SRC_W-1:0]          rf_wsrc;

  modport master (
    output req_valid, req_addr, req_data, wr_stall,
    input  req_ready, rf_we, rf_waddr, rf_wdata, rf_wsrc
  );

  modport slave (
    input  req_valid, req_addr, req_data, wr_stall,
    output req_ready, rf_we, rf_waddr, rf_wdata, rf_wsrc
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Purpose : Shares the single register-file write port among NUM_REQ
//           requesters using a round-robin grant, registering the winner
//           into one output stage (latency 1).
// Ports   : clk  - clock, all state on posedge
//           rst  - asynchronous, active-high reset
//           bus  - regfile_wr_arbiter_if.slave (requests, grant, rf_* port)
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  bus
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam logic [SRC_W-1:0] LAST = SRC_W'(NUM_REQ - 1);

  logic [SRC_W-1:0]   r_ptr;
  logic               r_we;
  logic [ADDR_W-1:0]  r_waddr;
  logic [WIDTH-1:0]   r_wdata;
  logic [SRC_W-1:0]   r_wsrc;

  logic               w_found;
  logic               w_xfer;
  logic [SRC_W-1:0]   w_gidx;
  logic [ADDR_W-1:0]  w_gaddr;
  logic [WIDTH-1:0]   w_gdata;
  logic [NUM_REQ-1:0] w_sel;
  logic [31:0]        w_ptr_u;

  // Rotating search done as two ascending passes: first indices >= ptr,
  // then indices < ptr. Equivalent to the modulo walk from ptr without
  // needing a wrap adder for non-power-of-2 NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_gaddr = '0;
    w_gdata = '0;
    w_sel   = '0;
    w_ptr_u = 32'(r_ptr);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && bus.req_valid[i] && (i >= w_ptr_u)) begin
        w_found  = 1'b1;
        w_gidx   = SRC_W'(i);
        w_gaddr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_gdata  = bus.req_data[i*WIDTH +: WIDTH];
        w_sel[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && bus.req_valid[i] && (i < w_ptr_u)) begin
        w_found  = 1'b1;
        w_gidx   = SRC_W'(i);
        w_gaddr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_gdata  = bus.req_data[i*WIDTH +: WIDTH];
        w_sel[i] = 1'b1;
      end
    end
  end

  // Grant is suppressed while the port is stalled or reset is held.
  assign w_xfer        = w_found & ~bus.wr_stall & ~rst;
  assign bus.req_ready = w_xfer ? w_sel : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wsrc  <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_xfer) begin
        r_ptr   <= (w_gidx == LAST) ? '0 : w_gidx + 1'b1;
        r_waddr <= w_gaddr;
        r_wdata <= w_gdata;
        r_wsrc  <= w_gidx;
        // x0 writes complete the handshake but never reach the register file
        r_we    <= (w_gaddr != '0);
      end
    end
  end

  assign bus.rf_we    = r_we;
  assign bus.rf_waddr = r_waddr;
  assign bus.rf_wdata = r_wdata;
  assign bus.rf_wsrc  = r_wsrc;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.NUM_REQ(4), .WIDTH(32), .ADDR_W(5)) b4 ();
  regfile_wr_arbiter_if #(.NUM_REQ(3), .WIDTH(32), .ADDR_W(5)) b3 ();

  regfile_wr_arbiter #(.NUM_REQ(4), .WIDTH(32), .ADDR_W(5)) u_dut4 (
    .clk(clk), .rst(rst), .bus(b4.slave)
  );
  regfile_wr_arbiter #(.NUM_REQ(3), .WIDTH(32), .ADDR_W(5)) u_dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // requester-side stimulus state for the 4-way instance
  logic [3:0]  v;
  logic [4:0]  a [4];
  logic [31:0] d [4];
  logic        stall;

  // reference model: pointer plus last accepted write
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_wsrc;

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_wsrc = 0;
  endtask

  task automatic drive4();
    b4.req_valid = v;
    b4.wr_stall  = stall;
    for (int i = 0; i < 4; i++) begin
      b4.req_addr[i*5 +: 5]   = a[i];
      b4.req_data[i*32 +: 32] = d[i];
    end
  endtask

  function automatic int ref_grant();
    if (rst || stall) return -1;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: grant checked mid-cycle, rf_* checked just after the edge.
  task automatic run_cycle(output int g, output logic [3:0] dut_ready);
    drive4();
    @(negedge clk);
    g = ref_grant();
    dut_ready = b4.req_ready;
    chk("ready", 64'(b4.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    if (g >= 0) begin
      m_waddr = a[g];
      m_wdata = d[g];
      m_wsrc  = g;
      m_we    = (a[g] != 0);
      m_ptr   = (g + 1) % 4;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rf_we",    64'(b4.rf_we),    64'(m_we));
    chk("rf_waddr", 64'(b4.rf_waddr), 64'(m_waddr));
    chk("rf_wdata", 64'(b4.rf_wdata), 64'(m_wdata));
    chk("rf_wsrc",  64'(b4.rf_wsrc),  64'(m_wsrc));
  endtask

  initial begin
    int g;
    logic [3:0] rdy;
    int rr_order [5] = '{0, 1, 2, 3, 0};

    b3.req_valid = '0; b3.req_addr = '0; b3.req_data = '0; b3.wr_stall = 1'b0;
    stall = 1'b0;
    v = 4'hF;
    for (int i = 0; i < 4; i++) begin
      a[i] = 5'(i + 1);
      d[i] = $urandom;
    end
    drive4();
    model_reset();

    // reset held with every requester valid
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ready", 64'(b4.req_ready), 64'd0);
      chk("rst_we",    64'(b4.rf_we),     64'd0);
      chk("rst_waddr", 64'(b4.rf_waddr),  64'd0);
      chk("rst_wdata", 64'(b4.rf_wdata),  64'd0);
    end
    rst = 1'b0;
    v = '0;
    drive4();

    // single request
    v = 4'b0100; a[2] = 5'd7; d[2] = 32'hDEAD_BEEF;
    run_cycle(g, rdy);
    v = '0;

    // round robin: bring ptr to 0, then all valid
    v = 4'b1000; a[3] = 5'd3; d[3] = $urandom;
    run_cycle(g, rdy);
    chk("ptr3_grant", 64'(rdy), 64'b1000);
    v = 4'hF;
    for (int i = 0; i < 5; i++) begin
      run_cycle(g, rdy);
      chk("rr_order", 64'(rdy), 64'd1 << rr_order[i]);
      if (g >= 0) begin
        a[g] = 5'($urandom_range(1, 31));
        d[g] = $urandom;
      end
    end

    // stall
    v = '0;
    run_cycle(g, rdy);
    v = 4'b1000; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_cycle(g, rdy);
      chk("stall_we", 64'(b4.rf_we), 64'd0);
    end
    stall = 1'b0;
    run_cycle(g, rdy);
    chk("unstall_grant", 64'(rdy), 64'b1000);
    chk("unstall_we", 64'(b4.rf_we), 64'd1);
    v = '0;

    // x0 write
    v = 4'b0001; a[0] = 5'd0; d[0] = 32'h1234_5678;
    run_cycle(g, rdy);
    chk("x0_grant", 64'(rdy), 64'b0001);
    chk("x0_we", 64'(b4.rf_we), 64'd0);

    // async reset right after a real write lands
    a[0] = 5'd9; d[0] = $urandom;
    run_cycle(g, rdy);
    v = '0;
    drive4();
    #2;
    rst = 1'b1;
    #1;
    chk("async_we",    64'(b4.rf_we),    64'd0);
    chk("async_waddr", 64'(b4.rf_waddr), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // 3-way instance: wrap from ptr=2
    b3.req_valid = 3'b010;
    b3.req_addr  = {5'd3, 5'd2, 5'd1};
    b3.req_data  = {32'hC, 32'hB, 32'hA};
    @(negedge clk);
    chk("n3_first", 64'(b3.req_ready), 64'b010);
    @(posedge clk); #1;
    chk("n3_src1", 64'(b3.rf_wsrc), 64'd1);
    b3.req_valid = 3'b011;
    @(negedge clk);
    chk("n3_wrap", 64'(b3.req_ready), 64'b001);
    @(posedge clk); #1;
    chk("n3_src0",  64'(b3.rf_wsrc),  64'd0);
    chk("n3_data0", 64'(b3.rf_wdata), 64'hA);
    b3.req_valid = 3'b010;
    @(negedge clk);
    chk("n3_ptr1", 64'(b3.req_ready), 64'b010);
    @(posedge clk); #1;
    b3.req_valid = '0;

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!v[i] && $urandom_range(0, 1) == 1) begin
          v[i] = 1'b1;
          a[i] = 5'($urandom_range(0, 31));
          d[i] = $urandom;
        end
      end
      run_cycle(g, rdy);
      if (g >= 0) begin
        if ($urandom_range(0, 1) == 1) begin
          v[g] = 1'b0;
        end else begin
          a[g] = 5'($urandom_range(0, 31));
          d[g] = $urandom;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
